// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control encodings: PC mux selects, sequencer states and the control bundle.
// The datapath PC mux imports the same PCSEL_* constants.
package pipe_ctrl_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_JMP = 2'd2;
  localparam logic [1:0] PCSEL_EXC = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_MASK = 2'd2
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       idex_hold;
    logic       exmem_hold;
    logic       epc_write;
    logic       stall_inc;
  } ctrl_t;

  // A load in EX whose destination is read by the instruction in ID; $0 never hazards.
  function automatic logic load_use_hazard(input logic       ex_mem_read,
                                           input logic [4:0] ex_rt,
                                           input logic [4:0] id_rs,
                                           input logic [4:0] id_rt,
                                           input logic       id_use_rs,
                                           input logic       id_use_rt);
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status from ID/EX/MEM in, stage enables and redirects out.
// master = datapath side, slave = the controller.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             id_jump;
  logic             ex_branch_taken;
  logic             id_illop;
  logic             id_xadr;
  logic             irq;
  logic             mem_busy;

  logic             pc_write;
  logic [1:0]       pc_sel;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             idex_hold;
  logic             exmem_hold;
  logic             epc_write;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt, id_jump,
           ex_branch_taken, id_illop, id_xadr, irq, mem_busy,
    input  pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, idex_hold,
           exmem_hold, epc_write, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_rt, id_jump,
           ex_branch_taken, id_illop, id_xadr, irq, mem_busy,
    output pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, idex_hold,
           exmem_hold, epc_write, stall_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/exception sequencer: load-use stall, branch/jump flush, exception redirect with
// a post-exception mask window, memory-wait freeze and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int EXC_MASK = 2,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int           MW        = $clog2(EXC_MASK + 1);
  localparam logic [MW-1:0] MASK_LOAD = MW'(EXC_MASK);

  state_e        state_q, state_d, ret_q, ret_d, eff_state;
  logic [MW-1:0] mask_cnt_q, mask_cnt_d;
  logic          irq_pending_q, irq_pending_d, irq_prev_q;
  logic          load_use, exc_req, irq_rise;
  ctrl_t         ctrl;

  // Releasing HOLD behaves exactly like the state it interrupted.
  assign eff_state = (state_q == ST_HOLD) ? ret_q : state_q;
  assign load_use  = load_use_hazard(hz.ex_mem_read, hz.ex_rt, hz.id_rs, hz.id_rt,
                                     hz.id_use_rs, hz.id_use_rt);
  assign exc_req   = (eff_state == ST_RUN) && (hz.id_illop || hz.id_xadr || irq_pending_q);
  assign irq_rise  = hz.irq && !irq_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      ret_q         <= ST_RUN;
      mask_cnt_q    <= '0;
      irq_pending_q <= 1'b0;
      irq_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      mask_cnt_q    <= mask_cnt_d;
      irq_pending_q <= irq_pending_d;
      irq_prev_q    <= hz.irq;
    end
  end

  always_comb begin
    state_d       = eff_state;
    ret_d         = ret_q;
    mask_cnt_d    = mask_cnt_q;
    irq_pending_d = irq_pending_q;
    if (hz.mem_busy) begin
      state_d = ST_HOLD;
      ret_d   = eff_state;
    end else if (!hz.ex_branch_taken && exc_req) begin
      state_d       = ST_MASK;
      mask_cnt_d    = MASK_LOAD;
      irq_pending_d = 1'b0;
    end else if (eff_state == ST_MASK) begin
      mask_cnt_d = mask_cnt_q - 1'b1;
      if (mask_cnt_q == MW'(1)) state_d = ST_RUN;
    end
    // A fresh edge outranks the clear of the interrupt being taken this cycle.
    if (irq_rise) irq_pending_d = 1'b1;
  end

  always_comb begin
    ctrl            = '0;
    ctrl.pc_write   = 1'b1;
    ctrl.ifid_write = 1'b1;
    ctrl.pc_sel     = PCSEL_SEQ;
    if (reset) begin
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_bubble = 1'b1;
    end else if (hz.mem_busy) begin
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      ctrl.idex_hold  = 1'b1;
      ctrl.exmem_hold = 1'b1;
      ctrl.stall_inc  = 1'b1;
    end else if (hz.ex_branch_taken) begin
      ctrl.pc_sel      = PCSEL_BR;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_bubble = 1'b1;
    end else if (exc_req) begin
      ctrl.pc_sel      = PCSEL_EXC;
      ctrl.epc_write   = 1'b1;
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_bubble = 1'b1;
    end else if (hz.id_jump) begin
      ctrl.pc_sel     = PCSEL_JMP;
      ctrl.ifid_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.idex_bubble = 1'b1;
      ctrl.stall_inc   = 1'b1;
    end
  end

  assign hz.pc_write    = ctrl.pc_write;
  assign hz.pc_sel      = ctrl.pc_sel;
  assign hz.ifid_write  = ctrl.ifid_write;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_bubble = ctrl.idex_bubble;
  assign hz.idex_hold   = ctrl.idex_hold;
  assign hz.exmem_hold  = ctrl.exmem_hold;
  assign hz.epc_write   = ctrl.epc_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (ctrl.stall_inc),
    .count_o (hz.stall_count)
  );

endmodule
